// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, parity-mode
// constants and a small timing helper.
package uart_pkg;

    // Receiver states (plain constants so older code can reuse them).
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PAR       = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    // Parity modes.
    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Counter value at which the start bit is re-checked. The IDLE cycle that
    // first sees the line low is already the first cycle of the half-bit wait,
    // and the counter is cleared on leaving IDLE, so the compare value is
    // DIV/2 - 2. Clamped for degenerate dividers below 4.
    function automatic int unsigned start_ticks(input int unsigned div);
        return (div >= 4) ? (div / 2 - 2) : 0;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset, loads RESET_VAL into both flops
//   d   - asynchronous input
//   q   - synchronized output
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit validation, mid-bit sampling, optional parity and
// one or two checked stop bits.
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   rx         - asynchronous serial line, idle high
//   data       - last received payload (LSB first on the line)
//   valid      - one-cycle strobe when data / error flags are updated
//   frame_err  - a checked stop bit was low (qualified by valid)
//   parity_err - parity mismatch (qualified by valid), 0 without parity
//   busy       - receiver is not idle
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = $clog2(DIV) + 1;

    localparam logic [CW-1:0] BIT_TC   = CW'(DIV - 1);
    localparam logic [CW-1:0] START_TC = CW'(start_ticks(DIV));
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam bit            HAS_PAR   = (PARITY != PAR_NONE);
    localparam bit            ODD_PAR   = (PARITY == PAR_ODD);

    logic rxs;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rxs)
    );

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_bit_q, par_bit_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 tick;

    assign tick = (cnt_q == BIT_TC);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        par_bit_d    = par_bit_q;
        ferr_acc_d   = ferr_acc_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (cnt_q == START_TC) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // Line back high at mid start bit: glitch, not a frame.
                    state_d = rxs ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (tick) begin
                    cnt_d   = '0;
                    shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                    if (bit_q == DATA_LAST) begin
                        bit_d      = '0;
                        ferr_acc_d = 1'b0;
                        state_d    = HAS_PAR ? ST_PAR : ST_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_PAR: begin
                if (tick) begin
                    cnt_d     = '0;
                    par_bit_d = rxs;
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_STOP: begin
                if (tick) begin
                    cnt_d = '0;
                    if (bit_q == STOP_LAST) begin
                        valid_d      = 1'b1;
                        data_d       = shreg_q;
                        frame_err_d  = ferr_acc_q | ~rxs;
                        parity_err_d = HAS_PAR && (((^shreg_q) ^ par_bit_q) != ODD_PAR);
                        // A low final stop bit means a break; wait for the line to recover.
                        state_d      = rxs ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        ferr_acc_d = ferr_acc_q | ~rxs;
                        bit_d      = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_WAIT_HIGH: begin
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            par_bit_q    <= 1'b0;
            ferr_acc_q   <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            par_bit_q    <= par_bit_d;
            ferr_acc_q   <= ferr_acc_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with CLK_HZ=16, BAUD=1 (DIV=16).
// Three receivers share clk/rst: 8N1, 8E1 and 8N2, each with its own rx line.
module tb_uart_rx;

    localparam int DIV = 16;
    localparam int N1  = 0;
    localparam int E1  = 1;
    localparam int N2  = 2;
    // Line drive to valid: 2 synchronizer cycles + DIV/2 + (bits-1)*DIV + DIV.
    localparam int LAT_N1 = 2 + 8 + 8 * DIV + DIV;   // 154
    localparam int LAT_E1 = 2 + 8 + 9 * DIV + DIV;   // 170

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_w       [3];
    logic [7:0] data_w     [3];
    logic       valid_w    [3];
    logic       frame_w    [3];
    logic       parity_w   [3];
    logic       busy_w     [3];

    int checks = 0;
    int errors = 0;

    int unsigned cyc = 0;
    int          vcnt      [3] = '{0, 0, 0};
    int unsigned vcyc      [3] = '{0, 0, 0};
    int unsigned vcyc_prev [3] = '{0, 0, 0};
    logic [7:0]  vdat      [3] = '{8'h0, 8'h0, 8'h0};
    logic [7:0]  vdat_prev [3] = '{8'h0, 8'h0, 8'h0};

    always #5 clk = ~clk;

    uart_rx #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .clk(clk), .rst(rst), .rx(rx_w[N1]), .data(data_w[N1]), .valid(valid_w[N1]),
        .frame_err(frame_w[N1]), .parity_err(parity_w[N1]), .busy(busy_w[N1])
    );

    uart_rx #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e1 (
        .clk(clk), .rst(rst), .rx(rx_w[E1]), .data(data_w[E1]), .valid(valid_w[E1]),
        .frame_err(frame_w[E1]), .parity_err(parity_w[E1]), .busy(busy_w[E1])
    );

    uart_rx #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_n2 (
        .clk(clk), .rst(rst), .rx(rx_w[N2]), .data(data_w[N2]), .valid(valid_w[N2]),
        .frame_err(frame_w[N2]), .parity_err(parity_w[N2]), .busy(busy_w[N2])
    );

    // Valid monitor: counts high cycles and records cycle/data of each pulse.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (valid_w[i]) begin
                vcnt[i]      <= vcnt[i] + 1;
                vcyc_prev[i] <= vcyc[i];
                vcyc[i]      <= cyc;
                vdat_prev[i] <= vdat[i];
                vdat[i]      <= data_w[i];
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends n line bits LSB first, DIV cycles each.
    task automatic send_frame(input int w, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_w[w] = bits[i];
            idle(DIV);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(4);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (data_w[i] !== 8'h00 || valid_w[i] !== 1'b0 || frame_w[i] !== 1'b0 ||
                parity_w[i] !== 1'b0 || busy_w[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got data=%h v=%b fe=%b pe=%b busy=%b expected all 0",
                         i, data_w[i], valid_w[i], frame_w[i], parity_w[i], busy_w[i]);
            end
        end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_8n1();
        int          base;
        int unsigned st;
        base = vcnt[N1];
        st   = cyc;
        send_frame(N1, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
        idle(8);
        checks++;
        if (vcnt[N1] - base !== 1) begin
            errors++;
            $display("FAIL 8n1_valid_count: got %0d expected 1", vcnt[N1] - base);
        end
        checks++;
        if (vcyc[N1] - st !== LAT_N1) begin
            errors++;
            $display("FAIL 8n1_latency: got %0d expected %0d", vcyc[N1] - st, LAT_N1);
        end
        checks++;
        if (data_w[N1] !== 8'hA5 || vdat[N1] !== 8'hA5) begin
            errors++;
            $display("FAIL 8n1_data: got %h/%h expected a5", data_w[N1], vdat[N1]);
        end
        checks++;
        if (frame_w[N1] !== 1'b0 || parity_w[N1] !== 1'b0 || busy_w[N1] !== 1'b0) begin
            errors++;
            $display("FAIL 8n1_flags: got fe=%b pe=%b busy=%b expected 0 0 0",
                     frame_w[N1], parity_w[N1], busy_w[N1]);
        end
    endtask

    task automatic test_parity();
        int          base;
        int unsigned st;
        // 0x07 has three ones; even parity bit 0 is wrong.
        base = vcnt[E1];
        st   = cyc;
        send_frame(E1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        idle(8);
        checks++;
        if (vcnt[E1] - base !== 1 || vcyc[E1] - st !== LAT_E1) begin
            errors++;
            $display("FAIL 8e1_valid: got count %0d latency %0d expected 1 %0d",
                     vcnt[E1] - base, vcyc[E1] - st, LAT_E1);
        end
        checks++;
        if (data_w[E1] !== 8'h07 || parity_w[E1] !== 1'b1 || frame_w[E1] !== 1'b0) begin
            errors++;
            $display("FAIL 8e1_bad_parity: got data=%h pe=%b fe=%b expected 07 1 0",
                     data_w[E1], parity_w[E1], frame_w[E1]);
        end
        send_frame(E1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
        idle(8);
        checks++;
        if (vcnt[E1] - base !== 2 || data_w[E1] !== 8'h07 || parity_w[E1] !== 1'b0) begin
            errors++;
            $display("FAIL 8e1_good_parity: got count %0d data=%h pe=%b expected 2 07 0",
                     vcnt[E1] - base, data_w[E1], parity_w[E1]);
        end
    endtask

    task automatic test_false_start();
        int base;
        base = vcnt[N1];
        rx_w[N1] = 1'b0;
        idle(4);
        rx_w[N1] = 1'b1;
        idle(3 * DIV);
        checks++;
        if (vcnt[N1] !== base || busy_w[N1] !== 1'b0) begin
            errors++;
            $display("FAIL false_start: got count %0d busy=%b expected 0 0",
                     vcnt[N1] - base, busy_w[N1]);
        end
        send_frame(N1, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);
        idle(8);
        checks++;
        if (vcnt[N1] - base !== 1 || data_w[N1] !== 8'h3C || frame_w[N1] !== 1'b0) begin
            errors++;
            $display("FAIL false_start_next: got count %0d data=%h fe=%b expected 1 3c 0",
                     vcnt[N1] - base, data_w[N1], frame_w[N1]);
        end
    endtask

    task automatic test_break();
        int base;
        base = vcnt[N1];
        rx_w[N1] = 1'b0;
        idle(20 * DIV);
        checks++;
        if (vcnt[N1] - base !== 1 || data_w[N1] !== 8'h00 || frame_w[N1] !== 1'b1) begin
            errors++;
            $display("FAIL break_frame: got count %0d data=%h fe=%b expected 1 00 1",
                     vcnt[N1] - base, data_w[N1], frame_w[N1]);
        end
        checks++;
        if (busy_w[N1] !== 1'b1) begin
            errors++;
            $display("FAIL break_busy: got %b expected 1", busy_w[N1]);
        end
        rx_w[N1] = 1'b1;
        idle(DIV);
        checks++;
        if (vcnt[N1] - base !== 1 || busy_w[N1] !== 1'b0) begin
            errors++;
            $display("FAIL break_release: got count %0d busy=%b expected 1 0",
                     vcnt[N1] - base, busy_w[N1]);
        end
        send_frame(N1, {6'b0, 1'b1, 8'h55, 1'b0}, 10);
        idle(8);
        checks++;
        if (vcnt[N1] - base !== 2 || data_w[N1] !== 8'h55 || frame_w[N1] !== 1'b0) begin
            errors++;
            $display("FAIL break_next: got count %0d data=%h fe=%b expected 2 55 0",
                     vcnt[N1] - base, data_w[N1], frame_w[N1]);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        base = vcnt[N1];
        // Start bit, bits 0..3 of 0xFF, then halfway into bit 4.
        send_frame(N1, 16'b0000_0000_0001_1110, 5);
        rx_w[N1] = 1'b1;
        idle(DIV / 2);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        checks++;
        if (valid_w[N1] !== 1'b0 || data_w[N1] !== 8'h00 || frame_w[N1] !== 1'b0 ||
            parity_w[N1] !== 1'b0 || busy_w[N1] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got v=%b data=%h fe=%b pe=%b busy=%b expected all 0",
                     valid_w[N1], data_w[N1], frame_w[N1], parity_w[N1], busy_w[N1]);
        end
        idle(5 * DIV);
        checks++;
        if (vcnt[N1] !== base) begin
            errors++;
            $display("FAIL rst_mid_no_valid: got %0d pulses expected 0", vcnt[N1] - base);
        end
        send_frame(N1, {6'b0, 1'b1, 8'h81, 1'b0}, 10);
        idle(8);
        checks++;
        if (vcnt[N1] - base !== 1 || data_w[N1] !== 8'h81) begin
            errors++;
            $display("FAIL rst_mid_next: got count %0d data=%h expected 1 81",
                     vcnt[N1] - base, data_w[N1]);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = vcnt[N2];
        send_frame(N2, {5'b0, 2'b11, 8'h12, 1'b0}, 11);
        send_frame(N2, {5'b0, 2'b11, 8'h34, 1'b0}, 11);
        idle(8);
        checks++;
        if (vcnt[N2] - base !== 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 2", vcnt[N2] - base);
        end
        checks++;
        if (vcyc[N2] - vcyc_prev[N2] !== 11 * DIV) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d expected %0d",
                     vcyc[N2] - vcyc_prev[N2], 11 * DIV);
        end
        checks++;
        if (vdat_prev[N2] !== 8'h12 || vdat[N2] !== 8'h34 || frame_w[N2] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_data: got %h then %h fe=%b expected 12 then 34 fe=0",
                     vdat_prev[N2], vdat[N2], frame_w[N2]);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) rx_w[i] = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_8n1();
        test_parity();
        test_false_start();
        test_break();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line bit rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, payload width; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, number of stop bits checked; legal values 1 or 2.
REQ-006 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port data  output  DATA_BITS  last received payload, LSB first on the line.
REQ-010 SHALL have port valid  output  1  one-cycle strobe: data and error flags updated.
REQ-011 SHALL have port frame_err  output  1  any checked stop bit sampled low; qualified by valid.
REQ-012 SHALL have port parity_err  output  1  parity mismatch; qualified by valid; always 0 when PARITY=0.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer (reset value 1) before any use; "rxs" below is the synchronized signal.
REQ-015 SHALL derive DIV = CLK_HZ/BAUD (integer division) at elaboration, with a baud counter of width clog2(DIV)+1.
REQ-016 SHALL implement states IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
REQ-017 IDLE: on rxs==0, SHALL go to START and clear the baud counter; otherwise SHALL stay in IDLE.
REQ-018 START: after DIV/2 cycles, SHALL resample rxs; 1 -> false start, return to IDLE with no valid pulse; 0 -> go to DATA.
REQ-019 DATA: SHALL sample rxs every DIV cycles (mid-bit), shifting LSB first; after DATA_BITS samples, SHALL go to PAR if PARITY!=0, else to STOP.
REQ-020 PAR: SHALL sample one bit after DIV cycles; parity_err = (XOR of payload and parity bit) != (PARITY==1 ? 1 : 0).
REQ-021 STOP: SHALL sample STOP_BITS bits at DIV-cycle spacing; frame_err = any stop sample==0.
REQ-022 At the final stop sample, SHALL pulse valid for exactly 1 cycle, and SHALL load data, frame_err and parity_err in that same cycle; the payload is delivered even when an error is flagged.
REQ-023 After valid, SHALL go to IDLE if the last stop sample==1, else to WAIT_HIGH.
REQ-024 WAIT_HIGH (break/line low): SHALL stay until rxs==1, then go to IDLE; no further valid pulses are generated while the line is held low.
REQ-025 Latency: valid SHALL rise exactly DIV/2 + (DATA_BITS + (PARITY!=0) + STOP_BITS - 1)*DIV + DIV cycles after the first cycle with rxs==0 in IDLE.
REQ-026 data, frame_err and parity_err SHALL hold their values between valid pulses.
REQ-027 A start edge arriving in the cycle after valid (back-to-back frames) SHALL be accepted with no lost character.

Reset
REQ-028 rst SHALL force state IDLE, baud counter 0, shift register 0, synchronizer flops 1, data 0, valid 0, frame_err 0, parity_err 0, busy 0.
REQ-029 rst asserted mid-frame SHALL abort the frame with no valid pulse; reception SHALL resume on the next start edge after rst deasserts.

Structure
REQ-030 The state encoding and the parity-mode constants (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2) SHALL live in shared package uart_pkg.
REQ-031 The synchronizer SHALL be sub-module sync_2ff (parameter RESET_VAL), reusable by the future transmitter and other async inputs.

Verification (CLK_HZ=16, BAUD=1, so DIV=16, unless noted)
REQ-032 8N1, send 0xA5 -> single valid pulse 152 cycles after rxs falls, data=0xA5, frame_err=0, parity_err=0.
REQ-033 8E1, send 0x07 with parity bit 0 -> data=0x07, parity_err=1; repeat with parity bit 1 -> parity_err=0.
REQ-034 rx low for 4 cycles, then high -> no valid pulse, busy returns to 0, and the next proper frame 0x3C is received correctly.
REQ-035 8N1, line held low for 20 bit times -> one valid with data=0x00 and frame_err=1, then no valid until rx goes high; the following frame 0x55 is received correctly.
REQ-036 rst pulse during bit 4 of 0xFF -> no valid pulse, all outputs 0; the next frame 0x81 is received correctly.
REQ-037 Two back-to-back 8N2 frames 0x12, 0x34 with no idle gap -> two valid pulses, 32+... spacing of exactly 11*DIV=176 cycles, data 0x12 then 0x34.
